// File: rtl/stft_frame_ctrl.sv
// stft_frame_ctrl
//
// Sequencer for a WIN-deep sample delay line built from enable/clear data
// registers that feeds an STFT stage. The controller clears the chain,
// accepts input samples under a valid/ready handshake and declares a frame
// once the window is full. After that it declares a new frame every HOP
// samples. Each frame is held until the downstream FFT acknowledges it.
//
// Handshake: a sample is transferred on a rising edge where iVALID=1 and
// oREADY=1. The chain registers capture on that same edge through oSH_EN.
// oREADY comes only from registered state and never depends on iVALID.
//
// Ports
//   iCLK        system clock, rising edge
//   iRSTn       asynchronous active-low reset
//   iSTART      single-cycle start pulse, sampled only in IDLE
//   iSTOP       single-cycle abort pulse, returns to IDLE from any state
//   iVALID      input sample present on the chain's data input
//   oREADY      controller accepts a sample this cycle
//   oSH_EN      shift enable to every chain register (iVALID & oREADY)
//   oSH_CLR     synchronous clear to every chain register
//   oFRAME_VLD  chain holds a complete frame
//   iFRAME_ACK  downstream has consumed the frame
//   oFRAME_IDX  index of the current or next frame
//   oFILL_CNT   samples accepted since the last clear, saturating at WIN
//   oBUSY       state is not IDLE

module stft_frame_ctrl #(
  parameter int WIN = 16,
  parameter int HOP = 8,
  parameter int CW  = 5,
  parameter int FW  = 8
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  input  logic          iSTOP,
  input  logic          iVALID,
  output logic          oREADY,
  output logic          oSH_EN,
  output logic          oSH_CLR,
  output logic          oFRAME_VLD,
  input  logic          iFRAME_ACK,
  output logic [FW-1:0] oFRAME_IDX,
  output logic [CW-1:0] oFILL_CNT,
  output logic          oBUSY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  // The final accept of a window or hop is detected one count early so
  // the transition to HOLD lands on the same edge as that accept.
  localparam logic [CW-1:0] LP_WIN_M1 = CW'(WIN - 1);
  localparam logic [CW-1:0] LP_HOP_M1 = CW'(HOP - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_hop;
  logic [FW-1:0] r_fidx;
  logic          r_ready;
  logic          r_sh_clr;
  logic          r_frame_vld;
  logic          r_busy;
  logic          w_accept;
  logic          w_abort;

  assign w_accept = iVALID & r_ready;
  assign w_abort  = iSTOP & (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (iSTART && !iSTOP) w_state_nxt = S_CLEAR;
        S_CLEAR: w_state_nxt = S_FILL;
        S_FILL:  if (w_accept && (r_fill == LP_WIN_M1)) w_state_nxt = S_HOLD;
        S_HOLD:  if (iFRAME_ACK) w_state_nxt = S_RUN;
        S_RUN:   if (w_accept && (r_hop == LP_HOP_M1)) w_state_nxt = S_HOLD;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counters and the registered output flags. The flags are decoded
  // from the next state so they line up with r_state on every cycle.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state     <= S_IDLE;
      r_fill      <= '0;
      r_hop       <= '0;
      r_fidx      <= '0;
      r_ready     <= 1'b0;
      r_sh_clr    <= 1'b0;
      r_frame_vld <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN);
      r_sh_clr    <= (w_state_nxt == S_CLEAR);
      r_frame_vld <= (w_state_nxt == S_HOLD);
      r_busy      <= (w_state_nxt != S_IDLE);

      if (w_abort) begin
        // Abort drops the window but keeps the frame index.
        r_fill <= '0;
        r_hop  <= '0;
      end else begin
        case (r_state)
          S_CLEAR: begin
            r_fill <= '0;
            r_hop  <= '0;
            r_fidx <= '0;
          end
          S_FILL: if (w_accept) r_fill <= r_fill + CW'(1);
          S_HOLD: begin
            if (iFRAME_ACK) begin
              r_fidx <= r_fidx + FW'(1);
              r_hop  <= '0;
            end
          end
          S_RUN: if (w_accept) r_hop <= r_hop + CW'(1);
          default: ;
        endcase
      end
    end
  end

  assign oREADY     = r_ready;
  assign oSH_EN     = w_accept;
  assign oSH_CLR    = r_sh_clr;
  assign oFRAME_VLD = r_frame_vld;
  assign oFRAME_IDX = r_fidx;
  assign oFILL_CNT  = r_fill;
  assign oBUSY      = r_busy;

endmodule

// File: doc/stft_frame_ctrl.md
Name: stft_frame_ctrl

Overview:
- Sequencer for a WIN-deep sample delay line built from enable/clear data registers feeding the STFT stage.
- Drives the shared shift-enable and synchronous-clear of the register chain, accepts input samples under a valid/ready handshake, and declares a frame once the window is full.
- After the first frame, it declares a new frame every HOP samples. Each frame is held until the downstream FFT acknowledges it.

Parameters:
- WIN, 16, window length in samples (chain depth); 2 <= WIN <= 2^CW-1.
- HOP, 8, hop size in samples between frames; 1 <= HOP <= WIN.
- CW, 5, width of the fill and hop counters.
- FW, 8, width of the frame index counter.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iSTART  in  1  single-cycle start pulse; sampled only in IDLE.
- iSTOP  in  1  single-cycle abort pulse; priority over all other inputs except reset.
- iVALID  in  1  input sample present on the chain's data input.
- oREADY  out  1  controller accepts a sample this cycle.
- oSH_EN  out  1  shift enable to every chain register's iEN; equals iVALID & oREADY.
- oSH_CLR  out  1  synchronous clear to every chain register's iCLR.
- oFRAME_VLD  out  1  chain holds a complete frame.
- iFRAME_ACK  in  1  downstream has consumed the frame.
- oFRAME_IDX  out  FW  index of the current or next frame.
- oFILL_CNT  out  CW  samples accepted since the last clear, saturating at WIN.
- oBUSY  out  1  state is not IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low (iRSTn), clocked on iCLK.
- Reset values: state IDLE; fill, hop and frame counters 0; oREADY, oSH_CLR, oFRAME_VLD and oBUSY all 0.
- All outputs decode from registered state and counters. oSH_EN is the only output with a combinational input path (iVALID).
- A sample is accepted at a rising edge where iVALID=1 and oREADY=1. The chain registers capture at that same edge.

States:
- IDLE: oREADY=0. iSTART=1 -> CLEAR.
- CLEAR (exactly 1 cycle): oSH_CLR=1, oREADY=0. Fill, hop and frame counters load 0. -> FILL.
- FILL: oREADY=1. Each accept increments the fill counter.
  - On the accept that makes the fill count WIN -> HOLD.
- HOLD: oREADY=0, oFRAME_VLD=1.
  - iFRAME_ACK=1 -> RUN; frame index +1, wrapping mod 2^FW; hop counter <= 0.
  - iFRAME_ACK while not in HOLD is ignored.
- RUN: oREADY=1. Each accept increments the hop counter.
  - On the accept that makes the hop count HOP -> HOLD.

Timing rules:
- oFRAME_VLD rises in the cycle after the completing accept. At that point the chain holds samples n-WIN+1..n.
- An ACK-to-next-frame cycle takes a minimum of HOP accept cycles plus 1. There is no back-to-back frame without an intervening accept.
- oFILL_CNT saturates at WIN in RUN and HOLD.

Boundary conditions:
- iSTOP in any non-IDLE state -> IDLE at the next edge.
  - oFRAME_VLD and oREADY drop at that edge.
  - Fill and hop counters clear; frame index holds.
  - A sample offered with iSTOP in the same cycle is still accepted if oREADY=1, since oSH_EN is unaffected that cycle.
- iSTART outside IDLE is ignored. iSTART and iSTOP together in IDLE: stay IDLE.
- iVALID in IDLE, CLEAR or HOLD: oSH_EN=0; the chain holds.
- HOP=WIN: frames do not overlap. HOP=1: a frame follows every accepted sample after the first.
- Reset mid-operation: immediate return to reset values regardless of state. The chain is reset by its own iRSTn.

Test Plan:
- Reset, then iSTART, then 16 consecutive iVALID cycles (WIN=16, HOP=8): oSH_CLR high exactly 1 cycle after iSTART. oSH_EN high for 16 cycles. oFRAME_VLD=1 in the cycle after the 16th accept. oREADY=0 and oFRAME_IDX=0 while in HOLD.
- ACK frame 0, then feed 8 samples with iVALID toggling 1/0: exactly 8 oSH_EN pulses. The second frame arrives with oFRAME_IDX=1. oFILL_CNT stays at 16.
- Hold iFRAME_ACK low for 20 cycles with iVALID=1 in HOLD: oSH_EN=0 throughout. oFRAME_VLD stays 1. Chain contents are unchanged.
- Assert iSTOP in the middle of RUN after 3 hop samples: IDLE next cycle. oBUSY=0, oFRAME_VLD=0, oFILL_CNT=0, oFRAME_IDX holds. A re-iSTART produces a fresh CLEAR pulse.
- Drop iRSTn asynchronously (between edges) during HOLD: all outputs read reset values before the next iCLK edge. After release, the block stays IDLE until iSTART.
- Run 256 ACKed frames with FW=8: oFRAME_IDX wraps from 255 to 0. Set HOP=1: oFRAME_VLD reasserts after every post-ACK accept.
